// File: rtl/led_pkg.sv
// Shared types and defaults for the LED PWM fader: FSM state encoding,
// default widths/rates and a counter-width helper.
package led_pkg;

   localparam int DEF_PWM_BITS    = 8;
   localparam int DEF_STEP_CYCLES = 125000;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      UP   = 2'd1,
      ON   = 2'd2,
      DOWN = 2'd3
   } fader_state_t;

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Request/status bundle between the heartbeat source and the LED fader.
interface led_pwm_fader_if
   import led_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
);

   logic                iLED;
   logic                iEN;
   logic                oLED;
   logic [PWM_BITS-1:0] oDUTY;
   logic                oBUSY;

   modport master (
      output iLED,
      output iEN,
      input  oLED,
      input  oDUTY,
      input  oBUSY
   );

   modport slave (
      input  iLED,
      input  iEN,
      output oLED,
      output oDUTY,
      output oBUSY
   );

endinterface

// File: rtl/step_tick_gen.sv
// Ramp step prescaler: counts 0..STEP_CYCLES-1 while running and flags the
// last count so the fader advances its duty once per step.
module step_tick_gen
   import led_pkg::*;
#(
   parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            CW   = cnt_width(STEP_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_r;

   // Step counter, held at zero whenever the ramp is idle or restarting.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         count_r <= ZERO;
      end else if (clear || !run) begin
         count_r <= ZERO;
      end else if (count_r == LAST) begin
         count_r <= ZERO;
      end else begin
         count_r <= count_r + ONE;
      end
   end

   assign tick = run && !clear && (count_r == LAST);

endmodule

// File: rtl/led_pwm_fader.sv
// Heartbeat LED fader: ramps a PWM duty between dark and full brightness
// following the requested LED level, with enable override.
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int PWM_BITS    = DEF_PWM_BITS,
   parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
   input  logic            iCLK,
   input  logic            iRST,
   led_pwm_fader_if.slave  bus
);

   localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

   fader_state_t        state_r;
   logic [PWM_BITS-1:0] duty_r;
   logic [PWM_BITS-1:0] pwm_r;
   logic                led_r;
   logic                busy_r;

   logic                reversal_s;
   logic                run_s;
   logic                clear_s;
   logic                tick_s;
   logic [PWM_BITS-1:0] duty_inc_s;
   logic [PWM_BITS-1:0] duty_dec_s;

   // Ramp control decode; saturating neighbours of the current duty.
   always_comb begin
      reversal_s = 1'b0;
      run_s      = 1'b0;
      duty_inc_s = duty_r;
      duty_dec_s = duty_r;
      case (state_r)
         UP: begin
            run_s      = 1'b1;
            reversal_s = !bus.iLED;
         end
         DOWN: begin
            run_s      = 1'b1;
            reversal_s = bus.iLED;
         end
         default: begin
            run_s      = 1'b0;
            reversal_s = 1'b0;
         end
      endcase
      if (duty_r != MAX) begin
         duty_inc_s = duty_r + ONE;
      end else begin
         duty_inc_s = MAX;
      end
      if (duty_r != ZERO) begin
         duty_dec_s = duty_r - ONE;
      end else begin
         duty_dec_s = ZERO;
      end
      clear_s = iRST || !bus.iEN || reversal_s;
   end

   step_tick_gen #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_step_tick_gen (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .clear (clear_s),
      .run   (run_s),
      .tick  (tick_s)
   );

   // Fade FSM; a reversal is checked before the tick so it wins a tie.
   always_ff @(posedge iCLK) begin
      if (iRST || !bus.iEN) begin
         state_r <= OFF;
         duty_r  <= ZERO;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            OFF: begin
               duty_r <= ZERO;
               if (bus.iLED) begin
                  state_r <= UP;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= OFF;
                  busy_r  <= 1'b0;
               end
            end
            UP: begin
               if (!bus.iLED) begin
                  state_r <= DOWN;
                  busy_r  <= 1'b1;
               end else if (tick_s) begin
                  duty_r <= duty_inc_s;
                  if (duty_inc_s == MAX) begin
                     state_r <= ON;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= UP;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  state_r <= UP;
                  busy_r  <= 1'b1;
               end
            end
            ON: begin
               duty_r <= MAX;
               if (!bus.iLED) begin
                  state_r <= DOWN;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ON;
                  busy_r  <= 1'b0;
               end
            end
            DOWN: begin
               if (bus.iLED) begin
                  state_r <= UP;
                  busy_r  <= 1'b1;
               end else if (tick_s) begin
                  duty_r <= duty_dec_s;
                  if (duty_dec_s == ZERO) begin
                     state_r <= OFF;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= DOWN;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  state_r <= DOWN;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= OFF;
               duty_r  <= ZERO;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Free-running PWM counter and comparator; full duty bypasses the compare
   // so the LED has no one-cycle gap per period.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         pwm_r <= ZERO;
         led_r <= 1'b0;
      end else begin
         pwm_r <= pwm_r + ONE;
         if (!bus.iEN) begin
            led_r <= 1'b0;
         end else if (duty_r == MAX) begin
            led_r <= 1'b1;
         end else begin
            led_r <= (pwm_r < duty_r);
         end
      end
   end

   assign bus.oLED  = led_r;
   assign bus.oDUTY = duty_r;
   assign bus.oBUSY = busy_r;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4 (MAX=15), STEP_CYCLES=3.
module tb_led_pwm_fader;

   localparam int PWM_BITS    = 4;
   localparam int STEP_CYCLES = 3;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   pwm_m;

   led_pwm_fader_if #(.PWM_BITS(PWM_BITS)) bus ();

   led_pwm_fader #(
      .PWM_BITS    (PWM_BITS),
      .STEP_CYCLES (STEP_CYCLES)
   ) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; pwm_m tracks the expected free-running PWM counter.
   task automatic step();
      @(posedge clk);
      if (rst) pwm_m = 0;
      else     pwm_m = (pwm_m + 1) % 16;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.iLED = 1'b1; bus.iEN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold c%0d: led=%b duty=%0d busy=%b, expected 0/0/0",
                     i, bus.oLED, bus.oDUTY, bus.oBUSY);
         end
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_release_up: duty=%0d busy=%b, expected 0/1", bus.oDUTY, bus.oBUSY);
      end
   endtask

   task automatic test_full_ramp();
      for (int k = 1; k <= 45; k++) begin
         step();
         vectors++;
         if ({bus.oDUTY, bus.oBUSY} !== {4'(k / 3), (k < 45)}) begin
            miscompares++;
            $display("FAIL ramp_up k=%0d: duty=%0d busy=%b, expected %0d/%b",
                     k, bus.oDUTY, bus.oBUSY, k / 3, (k < 45));
         end
      end
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {1'b1, 4'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL on_steady c%0d: led=%b duty=%0d busy=%b, expected 1/15/0",
                     i, bus.oLED, bus.oDUTY, bus.oBUSY);
         end
      end
   endtask

   task automatic test_ramp_down();
      bus.iLED = 1'b0;
      step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd15, 1'b1}) begin
         miscompares++;
         $display("FAIL down_entry: duty=%0d busy=%b, expected 15/1", bus.oDUTY, bus.oBUSY);
      end
      for (int k = 1; k <= 45; k++) begin
         step();
         vectors++;
         if ({bus.oDUTY, bus.oBUSY} !== {4'(15 - k / 3), (k < 45)}) begin
            miscompares++;
            $display("FAIL ramp_down k=%0d: duty=%0d busy=%b, expected %0d/%b",
                     k, bus.oDUTY, bus.oBUSY, 15 - k / 3, (k < 45));
         end
      end
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL off_steady c%0d: led=%b duty=%0d busy=%b, expected 0/0/0",
                     i, bus.oLED, bus.oDUTY, bus.oBUSY);
         end
      end
   endtask

   task automatic test_reversal();
      bus.iLED = 1'b1;
      step();
      for (int k = 1; k <= 23; k++) step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL pre_reversal: duty=%0d busy=%b, expected 7/1", bus.oDUTY, bus.oBUSY);
      end
      // the next edge carries a tick; the drop must win it
      bus.iLED = 1'b0;
      step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL reversal_on_tick: duty=%0d busy=%b, expected 7/1", bus.oDUTY, bus.oBUSY);
      end
      for (int k = 1; k <= 6; k++) begin
         step();
         vectors++;
         if ({bus.oDUTY, bus.oBUSY} !== {4'(7 - k / 3), 1'b1}) begin
            miscompares++;
            $display("FAIL after_reversal k=%0d: duty=%0d busy=%b, expected %0d/1",
                     k, bus.oDUTY, bus.oBUSY, 7 - k / 3);
         end
      end
   endtask

   task automatic test_pwm_hold();
      int prev_pwm;
      int highs;
      logic exp_led;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         bus.iLED = ~bus.iLED;
         prev_pwm = pwm_m;
         exp_led  = (prev_pwm < 5);
         step();
         vectors++;
         if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {exp_led, 4'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL pwm_hold c%0d pwm=%0d: led=%b duty=%0d busy=%b, expected %b/5/1",
                     i, prev_pwm, bus.oLED, bus.oDUTY, bus.oBUSY, exp_led);
         end
         if (i >= 8 && bus.oLED === 1'b1) highs++;
      end
      vectors++;
      if (highs !== 10) begin
         miscompares++;
         $display("FAIL pwm_ratio: %0d high cycles in 32, expected 10", highs);
      end
   endtask

   task automatic test_enable_override();
      int n;
      bus.iLED = 1'b1;
      n = 0;
      step();
      while (bus.oDUTY !== 4'd9 && n < 60) begin
         step();
         n++;
      end
      vectors++;
      if (n >= 60) begin
         miscompares++;
         $display("FAIL reach_duty9: timeout, duty=%0d, expected 9", bus.oDUTY);
      end
      bus.iEN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL enable_off c%0d: led=%b duty=%0d busy=%b, expected 0/0/0",
                     i, bus.oLED, bus.oDUTY, bus.oBUSY);
         end
      end
      bus.iEN = 1'b1;
      step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL enable_restart: duty=%0d busy=%b, expected 0/1", bus.oDUTY, bus.oBUSY);
      end
      step(); step(); step();
      vectors++;
      if (bus.oDUTY !== 4'd1) begin
         miscompares++;
         $display("FAIL enable_first_step: duty=%0d, expected 1", bus.oDUTY);
      end
   endtask

   task automatic test_reset_mid_ramp();
      step(); step(); step();
      rst = 1'b1;
      step();
      vectors++;
      if ({bus.oLED, bus.oDUTY, bus.oBUSY} !== {1'b0, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_ramp: led=%b duty=%0d busy=%b, expected 0/0/0",
                  bus.oLED, bus.oDUTY, bus.oBUSY);
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({bus.oDUTY, bus.oBUSY} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_mid_restart: duty=%0d busy=%b, expected 0/1", bus.oDUTY, bus.oBUSY);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      pwm_m       = 0;
      rst         = 1'b1;
      bus.iLED    = 1'b0;
      bus.iEN     = 1'b1;
      test_reset();
      test_full_ramp();
      test_ramp_down();
      test_reversal();
      test_pwm_hold();
      test_enable_override();
      test_reset_mid_ramp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
